backward_batch: RTL and testbench
=================================

Name: backward_batch

Overview:
- Parametrised backpropagation gradient engine for a 1-hidden-layer sigmoid network with N_IN inputs, N_HID hidden units and N_OUT outputs.
- Takes one training sample per cycle (forward activations, supervisor data, current w3 weights) through a 4-stage pipeline, and accumulates the weight and bias gradients over BATCH samples with saturation.
- Presents each finished batch sum on a valid/ready output for the weight-update block.
- Supersedes the fixed 2-3-2, single-sample, unhandshaked gradient datapath.

Parameters:
- N_IN, 2, input-layer width (k vector length)
- N_HID, 3, hidden-layer width (a2 length)
- N_OUT, 2, output-layer width (a3, t length)
- W, 16, signed fixed-point word width
- FRAC, 10, fractional bits (1.0 = 1<<FRAC)
- BATCH, 4, samples per accumulated batch, >=1

Ports:
- clk  in  1  clock, all logic on rising edge
- res  in  1  synchronous active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  sample accepted when in_valid && in_ready
- k  in  N_IN*W  supervisor data, element i at [i*W +: W]
- a2  in  N_HID*W  hidden outputs
- a3  in  N_OUT*W  output-layer outputs
- t  in  N_OUT*W  supervisor values
- w3  in  N_HID*N_OUT*W  weights, element (i,j) at index i*N_OUT+j
- flush  in  1  close the current batch early (partial batch)
- out_valid  out  1  gradient sums valid
- out_ready  in  1  consumer accepts on out_valid && out_ready
- grad_w3  out  N_HID*N_OUT*W  sum of delta3_j*a2_i, index i*N_OUT+j
- grad_w2  out  N_IN*N_HID*W  sum of delta2_h*k_i, index i*N_HID+h
- grad_b3  out  N_OUT*W  sum of delta3_j
- grad_b2  out  N_HID*W  sum of delta2_h
- out_count  out  $clog2(BATCH+1)  samples contained in the presented sums

Behaviour:
- Arithmetic: every product is the full 2W-bit product arithmetic-shifted right by FRAC (floor). The result is then saturated to W bits [-2^(W-1), 2^(W-1)-1]. Adds also saturate. No wrap-around anywhere.
- Stage 1:
  - dadz = a*((1<<FRAC)-a) for every a2 and a3
  - err_j = a3_j - t_j
  - k, a2 and w3 carried forward
- Stage 2: delta3_j = err_j*dadz3_j.
- Stage 3: s_h = sat sum over j of (w3_hj*delta3_j), each term truncated before the sum. delta2_h = dadz2_h*s_h.
- Stage 4: accumulators += delta3_j*a2_i, delta2_h*k_i, delta3_j, delta2_h. All operands are aligned to the same sample by delay registers.
- Throughput is 1 sample/cycle while in state ACCUM.
- State machine:
  - ACCUM: in_ready=1. The BATCH-th accepted sample, or flush with at least 1 sample accepted or in flight, goes to DRAIN.
  - DRAIN: in_ready=0. Waits until the last sample of the batch leaves stage 4, then copies the accumulators to the output registers, clears the accumulators, sets out_valid and goes to HOLD.
  - HOLD: in_ready=0, out_valid=1, outputs stable. On out_ready, clears out_valid and returns to ACCUM.
- Latency: out_valid rises 4 cycles after the clock edge that accepted the last sample of the batch.
- flush:
  - flush in the same cycle as an accepted sample includes that sample.
  - flush with 0 samples is ignored.
  - flush outside ACCUM is ignored.
- A sample accepted together with a completing batch belongs to that batch (BATCH counting).
- out_count = BATCH for a full batch, or n for a flushed batch.
- Reset (res=0 at an edge, any state, including mid-batch):
  - pipeline, accumulators, all grad_*, out_count cleared to 0
  - out_valid=0
  - state ACCUM, so in_ready=1 on the first cycle after reset
  - in-flight samples are discarded

Test Plan:
- Base sample (FRAC=10, BATCH=1): a3 all 512, t all 1024, a2 all 512, k all 1024, w3 all 1024, 1 cycle valid -> out_valid after 4 cycles, with:
  - grad_b3 all -128
  - grad_w3 all -64
  - grad_b2 all -64
  - grad_w2 all -64
  - out_count=1
- BATCH=4, same sample on 4 consecutive cycles -> single out_valid 4 cycles after the 4th accept; grad_b3=-512, grad_w3=-256, grad_b2=-256, grad_w2=-256; in_ready low from the cycle after the 4th accept until out_ready.
- Saturation: BATCH=16, a2 all 32767, other inputs as in the base sample, 16 samples -> grad_w3 all -32768 (per-sample term -4096), no wrap; grad_b3=-2048.
- Flush + backpressure: BATCH=4, 2 samples then flush -> out_count=2 with doubled base values. out_ready held low 10 cycles -> outputs stable and in_ready=0 throughout; accept then returns to ACCUM.
- Reset mid-operation: res=0 for 1 cycle during DRAIN -> out_valid never asserts for that batch; all outputs 0 and in_ready=1 next cycle. The next single sample with BATCH=1 gives the base-sample values.
- Non-default shape N_IN=3, N_HID=4, N_OUT=1, W=18, FRAC=12, with inputs scaled to 1.0=4096 and otherwise as in the base sample -> grad_b3=-512, grad_w3=-256. delta2 = dadz2*(w3*delta3) = 1024*(-512)>>12 = -128, so grad_b2 and grad_w2 are -128 on every index.

Source files
------------

// File: rtl/backward_batch.sv
// backward_batch: batched backpropagation gradient engine for a
// 1-hidden-layer sigmoid network (N_IN -> N_HID -> N_OUT).
//
// One training sample per cycle goes through a 4-stage pipeline:
//   stage 1: sigmoid derivatives dadz = a*(1-a), output error a3-t
//   stage 2: delta3 = err * dadz3
//   stage 3: delta2 = dadz2 * sum_j(w3_hj * delta3_j)
//   stage 4: saturating accumulation of weight and bias gradients
// BATCH samples (or fewer, on flush) are summed. The sums are then
// presented on a valid/ready output until the consumer takes them.
//
// Ports:
//   clk, res            clock, synchronous active-low reset
//   in_valid/in_ready   sample handshake
//   k, a2, a3, t, w3    packed sample operands, element e at [e*W +: W]
//   flush               close the current batch early
//   out_valid/out_ready gradient-sum handshake
//   grad_w3, grad_w2    weight gradient sums
//   grad_b3, grad_b2    bias gradient sums
//   out_count           number of samples in the presented sums
module backward_batch #(
  parameter int N_IN  = 2,
  parameter int N_HID = 3,
  parameter int N_OUT = 2,
  parameter int W     = 16,
  parameter int FRAC  = 10,
  parameter int BATCH = 4
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_IN*W-1:0]              k,
  input  logic [N_HID*W-1:0]             a2,
  input  logic [N_OUT*W-1:0]             a3,
  input  logic [N_OUT*W-1:0]             t,
  input  logic [N_HID*N_OUT*W-1:0]       w3,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_HID*N_OUT*W-1:0]       grad_w3,
  output logic [N_IN*N_HID*W-1:0]        grad_w2,
  output logic [N_OUT*W-1:0]             grad_b3,
  output logic [N_HID*W-1:0]             grad_b2,
  output logic [$clog2(BATCH+1)-1:0]     out_count
);

  localparam int CW = $clog2(BATCH+1);
  localparam int NW3 = N_HID*N_OUT;
  localparam int NW2 = N_IN*N_HID;
  localparam logic signed [W:0] ONE = (W+1)'(1 << FRAC);
  localparam logic signed [2*W+1:0] MAXV = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W+1:0] MINV = {{(W+3){1'b1}}, {(W-1){1'b0}}};

  function automatic logic signed [W-1:0] sat_w(input logic signed [2*W+1:0] x);
    if (x > MAXV) return MAXV[W-1:0];
    if (x < MINV) return MINV[W-1:0];
    return x[W-1:0];
  endfunction

  function automatic logic signed [W:0] ext(input logic signed [W-1:0] x);
    return (W+1)'(x);
  endfunction

  // Full product, floor shift by FRAC, then saturate to W bits.
  function automatic logic signed [W-1:0] mul_q(input logic signed [W:0] x,
                                                input logic signed [W:0] y);
    logic signed [2*W+1:0] p;
    p = (2*W+2)'(x) * (2*W+2)'(y);
    return sat_w(p >>> FRAC);
  endfunction

  function automatic logic signed [W-1:0] add_s(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] y);
    logic signed [2*W+1:0] s;
    s = (2*W+2)'(x) + (2*W+2)'(y);
    return sat_w(s);
  endfunction

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;
  state_t state, state_n;

  logic            take, load;
  logic [CW-1:0]   cnt;

  logic signed [W-1:0] k_in [N_IN];
  logic signed [W-1:0] a2_in [N_HID];
  logic signed [W-1:0] a3_in [N_OUT];
  logic signed [W-1:0] t_in [N_OUT];
  logic signed [W-1:0] w3_in [NW3];

  logic                vld_p0, vld_p1, vld_p2;
  logic signed [W-1:0] dadz2_p0 [N_HID];
  logic signed [W-1:0] dadz3_p0 [N_OUT];
  logic signed [W-1:0] err_p0 [N_OUT];
  logic signed [W-1:0] k_p0 [N_IN];
  logic signed [W-1:0] a2_p0 [N_HID];
  logic signed [W-1:0] w3_p0 [NW3];
  logic signed [W-1:0] delta3_p1 [N_OUT];
  logic signed [W-1:0] dadz2_p1 [N_HID];
  logic signed [W-1:0] k_p1 [N_IN];
  logic signed [W-1:0] a2_p1 [N_HID];
  logic signed [W-1:0] w3_p1 [NW3];
  logic signed [W-1:0] s_c [N_HID];
  logic signed [W-1:0] delta3_p2 [N_OUT];
  logic signed [W-1:0] delta2_p2 [N_HID];
  logic signed [W-1:0] k_p2 [N_IN];
  logic signed [W-1:0] a2_p2 [N_HID];

  logic signed [W-1:0] acc_w3 [NW3];
  logic signed [W-1:0] acc_w2 [NW2];
  logic signed [W-1:0] acc_b3 [N_OUT];
  logic signed [W-1:0] acc_b2 [N_HID];
  logic signed [W-1:0] gw3_q [NW3];
  logic signed [W-1:0] gw2_q [NW2];
  logic signed [W-1:0] gb3_q [N_OUT];
  logic signed [W-1:0] gb2_q [N_HID];

  for (genvar i = 0; i < N_IN; i++) begin : g_k
    assign k_in[i] = k[i*W +: W];
  end
  for (genvar i = 0; i < N_HID; i++) begin : g_a2
    assign a2_in[i] = a2[i*W +: W];
  end
  for (genvar i = 0; i < N_OUT; i++) begin : g_a3
    assign a3_in[i] = a3[i*W +: W];
    assign t_in[i]  = t[i*W +: W];
  end
  for (genvar i = 0; i < NW3; i++) begin : g_w3
    assign w3_in[i] = w3[i*W +: W];
  end

  // in_ready is a pure function of state, so take never loops back on itself.
  assign take = in_valid && (state == ACCUM);

  always_ff @(posedge clk) begin
    if (!res) state <= ACCUM;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    load     = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (take && (cnt == CW'(BATCH-1)))      state_n = DRAIN;
        else if (flush && (take || cnt != '0))  state_n = DRAIN;
      end
      DRAIN: begin
        // The batch is complete once its last sample has left stage 4.
        if (!vld_p0 && !vld_p1 && !vld_p2) begin
          load    = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      cnt       <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        cnt       <= '0;
        out_count <= cnt;
        out_valid <= 1'b1;
      end else begin
        if (take) cnt <= cnt + CW'(1);
        if (state == HOLD && out_ready) out_valid <= 1'b0;
      end
    end
  end

  // ---- stage 1 -> p0: derivatives and output error ----
  always_ff @(posedge clk) begin
    if (!res) begin
      vld_p0 <= 1'b0;
      for (int i = 0; i < N_IN; i++)  k_p0[i] <= '0;
      for (int h = 0; h < N_HID; h++) begin
        a2_p0[h]    <= '0;
        dadz2_p0[h] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) begin
        dadz3_p0[j] <= '0;
        err_p0[j]   <= '0;
      end
      for (int m = 0; m < NW3; m++) w3_p0[m] <= '0;
    end else begin
      vld_p0 <= take;
      for (int i = 0; i < N_IN; i++)  k_p0[i] <= k_in[i];
      for (int h = 0; h < N_HID; h++) begin
        a2_p0[h]    <= a2_in[h];
        dadz2_p0[h] <= mul_q(ext(a2_in[h]), ONE - ext(a2_in[h]));
      end
      for (int j = 0; j < N_OUT; j++) begin
        dadz3_p0[j] <= mul_q(ext(a3_in[j]), ONE - ext(a3_in[j]));
        err_p0[j]   <= add_s(a3_in[j], -t_in[j] - W'(0)) ;
      end
      for (int m = 0; m < NW3; m++) w3_p0[m] <= w3_in[m];
    end
  end

  // ---- stage 2 -> p1: output-layer delta ----
  always_ff @(posedge clk) begin
    if (!res) begin
      vld_p1 <= 1'b0;
      for (int i = 0; i < N_IN; i++)  k_p1[i] <= '0;
      for (int h = 0; h < N_HID; h++) begin
        a2_p1[h]    <= '0;
        dadz2_p1[h] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) delta3_p1[j] <= '0;
      for (int m = 0; m < NW3; m++)   w3_p1[m] <= '0;
    end else begin
      vld_p1 <= vld_p0;
      for (int i = 0; i < N_IN; i++)  k_p1[i] <= k_p0[i];
      for (int h = 0; h < N_HID; h++) begin
        a2_p1[h]    <= a2_p0[h];
        dadz2_p1[h] <= dadz2_p0[h];
      end
      for (int j = 0; j < N_OUT; j++) delta3_p1[j] <= mul_q(ext(err_p0[j]), ext(dadz3_p0[j]));
      for (int m = 0; m < NW3; m++)   w3_p1[m] <= w3_p0[m];
    end
  end

  // Back-propagated error per hidden unit; each term is truncated before the sum.
  always_comb begin
    for (int h = 0; h < N_HID; h++) begin
      s_c[h] = '0;
      for (int j = 0; j < N_OUT; j++)
        s_c[h] = add_s(s_c[h], mul_q(ext(w3_p1[h*N_OUT+j]), ext(delta3_p1[j])));
    end
  end

  // ---- stage 3 -> p2: hidden-layer delta ----
  always_ff @(posedge clk) begin
    if (!res) begin
      vld_p2 <= 1'b0;
      for (int i = 0; i < N_IN; i++)  k_p2[i] <= '0;
      for (int h = 0; h < N_HID; h++) begin
        a2_p2[h]     <= '0;
        delta2_p2[h] <= '0;
      end
      for (int j = 0; j < N_OUT; j++) delta3_p2[j] <= '0;
    end else begin
      vld_p2 <= vld_p1;
      for (int i = 0; i < N_IN; i++)  k_p2[i] <= k_p1[i];
      for (int h = 0; h < N_HID; h++) begin
        a2_p2[h]     <= a2_p1[h];
        delta2_p2[h] <= mul_q(ext(dadz2_p1[h]), ext(s_c[h]));
      end
      for (int j = 0; j < N_OUT; j++) delta3_p2[j] <= delta3_p1[j];
    end
  end

  // ---- stage 4: batch accumulators and presented sums ----
  always_ff @(posedge clk) begin
    if (!res || load) begin
      for (int m = 0; m < NW3; m++)   acc_w3[m] <= '0;
      for (int m = 0; m < NW2; m++)   acc_w2[m] <= '0;
      for (int j = 0; j < N_OUT; j++) acc_b3[j] <= '0;
      for (int h = 0; h < N_HID; h++) acc_b2[h] <= '0;
    end else if (vld_p2) begin
      for (int i = 0; i < N_HID; i++)
        for (int j = 0; j < N_OUT; j++)
          acc_w3[i*N_OUT+j] <= add_s(acc_w3[i*N_OUT+j], mul_q(ext(delta3_p2[j]), ext(a2_p2[i])));
      for (int i = 0; i < N_IN; i++)
        for (int h = 0; h < N_HID; h++)
          acc_w2[i*N_HID+h] <= add_s(acc_w2[i*N_HID+h], mul_q(ext(delta2_p2[h]), ext(k_p2[i])));
      for (int j = 0; j < N_OUT; j++) acc_b3[j] <= add_s(acc_b3[j], delta3_p2[j]);
      for (int h = 0; h < N_HID; h++) acc_b2[h] <= add_s(acc_b2[h], delta2_p2[h]);
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      for (int m = 0; m < NW3; m++)   gw3_q[m] <= '0;
      for (int m = 0; m < NW2; m++)   gw2_q[m] <= '0;
      for (int j = 0; j < N_OUT; j++) gb3_q[j] <= '0;
      for (int h = 0; h < N_HID; h++) gb2_q[h] <= '0;
    end else if (load) begin
      for (int m = 0; m < NW3; m++)   gw3_q[m] <= acc_w3[m];
      for (int m = 0; m < NW2; m++)   gw2_q[m] <= acc_w2[m];
      for (int j = 0; j < N_OUT; j++) gb3_q[j] <= acc_b3[j];
      for (int h = 0; h < N_HID; h++) gb2_q[h] <= acc_b2[h];
    end
  end

  for (genvar m = 0; m < NW3; m++) begin : g_ow3
    assign grad_w3[m*W +: W] = gw3_q[m];
  end
  for (genvar m = 0; m < NW2; m++) begin : g_ow2
    assign grad_w2[m*W +: W] = gw2_q[m];
  end
  for (genvar j = 0; j < N_OUT; j++) begin : g_ob3
    assign grad_b3[j*W +: W] = gb3_q[j];
  end
  for (genvar h = 0; h < N_HID; h++) begin : g_ob2
    assign grad_b2[h*W +: W] = gb2_q[h];
  end

endmodule

// File: tb/tb_backward_batch.sv
module tb_backward_batch;

  localparam int NI = 2;
  localparam int NH = 3;
  localparam int NO = 2;
  // Instances 0..2: default shape with BATCH 1, 4, 16. Instance 3: 3-4-1, W=18.
  localparam int C_NIN[4]   = '{2, 2, 2, 3};
  localparam int C_NHID[4]  = '{3, 3, 3, 4};
  localparam int C_NOUT[4]  = '{2, 2, 2, 1};
  localparam int C_W[4]     = '{16, 16, 16, 18};
  localparam int C_FRAC[4]  = '{10, 10, 10, 12};
  localparam int C_BATCH[4] = '{1, 4, 16, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rs[4], iv[4], fl[4], ordy[4], ir[4], ov[4];
  logic [NI*16-1:0]    k_d;
  logic [NH*16-1:0]    a2_d;
  logic [NO*16-1:0]    a3_d, t_d;
  logic [NH*NO*16-1:0] w3_d;
  logic [3*18-1:0]     k_s;
  logic [4*18-1:0]     a2_s, w3_s;
  logic [17:0]         a3_s, t_s;
  logic [511:0]        gw3_v[4], gw2_v[4], gb3_v[4], gb2_v[4];
  logic [7:0]          oc_v[4];

  for (genvar g = 0; g < 3; g++) begin : g_def
    localparam int BB = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    logic [NH*NO*16-1:0]     w3o;
    logic [NI*NH*16-1:0]     w2o;
    logic [NO*16-1:0]        b3o;
    logic [NH*16-1:0]        b2o;
    logic [$clog2(BB+1)-1:0] co;
    backward_batch #(.N_IN(NI), .N_HID(NH), .N_OUT(NO), .W(16), .FRAC(10), .BATCH(BB)) u_dut (
      .clk(clk), .res(rs[g]), .in_valid(iv[g]), .in_ready(ir[g]),
      .k(k_d), .a2(a2_d), .a3(a3_d), .t(t_d), .w3(w3_d), .flush(fl[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .grad_w3(w3o), .grad_w2(w2o), .grad_b3(b3o), .grad_b2(b2o), .out_count(co));
    assign gw3_v[g] = 512'(w3o);
    assign gw2_v[g] = 512'(w2o);
    assign gb3_v[g] = 512'(b3o);
    assign gb2_v[g] = 512'(b2o);
    assign oc_v[g]  = 8'(co);
  end

  logic [4*18-1:0]  s_w3o;
  logic [12*18-1:0] s_w2o;
  logic [17:0]      s_b3o;
  logic [4*18-1:0]  s_b2o;
  logic [0:0]       s_co;
  backward_batch #(.N_IN(3), .N_HID(4), .N_OUT(1), .W(18), .FRAC(12), .BATCH(1)) u_shape (
    .clk(clk), .res(rs[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .k(k_s), .a2(a2_s), .a3(a3_s), .t(t_s), .w3(w3_s), .flush(fl[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]),
    .grad_w3(s_w3o), .grad_w2(s_w2o), .grad_b3(s_b3o), .grad_b2(s_b2o), .out_count(s_co));
  assign gw3_v[3] = 512'(s_w3o);
  assign gw2_v[3] = 512'(s_w2o);
  assign gb3_v[3] = 512'(s_b3o);
  assign gb2_v[3] = 512'(s_b2o);
  assign oc_v[3]  = 8'(s_co);

  // Current sample operands (element values, shared by all instances).
  longint in_k[8], in_a2[8], in_a3[8], in_t[8], in_w3[16];

  // Reference model: running batch sums per instance.
  longint m_w3[4][16], m_w2[4][16], m_b3[4][8], m_b2[4][8];
  int     m_cnt[4];

  typedef struct {
    int     inst;
    int     cnt;
    longint w3[16];
    longint w2[16];
    longint b3[8];
    longint b2[8];
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic longint sat(input longint x, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w-1)) - 1;
    lo = -(longint'(1) << (w-1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic longint qmul(input longint a, input longint b, input int w, input int frac);
    return sat((a * b) >>> frac, w);
  endfunction

  function automatic longint elem(input logic [511:0] v, input int idx, input int w);
    longint r;
    r = 0;
    for (int b = 0; b < w; b++) r[b] = v[idx*w+b];
    if (r[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  task automatic model_add(input int inst);
    int nin, nh, no, w, fr;
    longint one, s;
    longint dz2[8], dz3[8], d3[8], d2[8];
    nin = C_NIN[inst]; nh = C_NHID[inst]; no = C_NOUT[inst]; w = C_W[inst]; fr = C_FRAC[inst];
    one = longint'(1) << fr;
    for (int h = 0; h < nh; h++) dz2[h] = qmul(in_a2[h], one - in_a2[h], w, fr);
    for (int j = 0; j < no; j++) begin
      dz3[j] = qmul(in_a3[j], one - in_a3[j], w, fr);
      d3[j]  = qmul(sat(in_a3[j] - in_t[j], w), dz3[j], w, fr);
    end
    for (int h = 0; h < nh; h++) begin
      s = 0;
      for (int j = 0; j < no; j++) s = sat(s + qmul(in_w3[h*no+j], d3[j], w, fr), w);
      d2[h] = qmul(dz2[h], s, w, fr);
    end
    for (int i = 0; i < nh; i++)
      for (int j = 0; j < no; j++)
        m_w3[inst][i*no+j] = sat(m_w3[inst][i*no+j] + qmul(d3[j], in_a2[i], w, fr), w);
    for (int i = 0; i < nin; i++)
      for (int h = 0; h < nh; h++)
        m_w2[inst][i*nh+h] = sat(m_w2[inst][i*nh+h] + qmul(d2[h], in_k[i], w, fr), w);
    for (int j = 0; j < no; j++) m_b3[inst][j] = sat(m_b3[inst][j] + d3[j], w);
    for (int h = 0; h < nh; h++) m_b2[inst][h] = sat(m_b2[inst][h] + d2[h], w);
    m_cnt[inst]++;
  endtask

  task automatic model_close(input int inst);
    exp_t e;
    e.inst = inst;
    e.cnt  = m_cnt[inst];
    for (int m = 0; m < 16; m++) begin
      e.w3[m] = m_w3[inst][m]; e.w2[m] = m_w2[inst][m];
      m_w3[inst][m] = 0; m_w2[inst][m] = 0;
    end
    for (int m = 0; m < 8; m++) begin
      e.b3[m] = m_b3[inst][m]; e.b2[m] = m_b2[inst][m];
      m_b3[inst][m] = 0; m_b2[inst][m] = 0;
    end
    m_cnt[inst] = 0;
    sb.push_back(e);
  endtask

  task automatic drive_data(input int inst);
    if (inst == 3) begin
      for (int i = 0; i < 3; i++) k_s[i*18 +: 18] = 18'(in_k[i]);
      for (int i = 0; i < 4; i++) a2_s[i*18 +: 18] = 18'(in_a2[i]);
      for (int i = 0; i < 4; i++) w3_s[i*18 +: 18] = 18'(in_w3[i]);
      a3_s = 18'(in_a3[0]);
      t_s  = 18'(in_t[0]);
    end else begin
      for (int i = 0; i < NI; i++) k_d[i*16 +: 16] = 16'(in_k[i]);
      for (int i = 0; i < NH; i++) a2_d[i*16 +: 16] = 16'(in_a2[i]);
      for (int i = 0; i < NO; i++) begin
        a3_d[i*16 +: 16] = 16'(in_a3[i]);
        t_d[i*16 +: 16]  = 16'(in_t[i]);
      end
      for (int i = 0; i < NH*NO; i++) w3_d[i*16 +: 16] = 16'(in_w3[i]);
    end
  endtask

  task automatic set_base(input int inst, input longint a2v);
    longint one;
    one = longint'(1) << C_FRAC[inst];
    for (int i = 0; i < 8; i++) begin
      in_k[i] = one; in_a2[i] = a2v; in_a3[i] = one / 2; in_t[i] = one;
    end
    for (int m = 0; m < 16; m++) in_w3[m] = one;
  endtask

  task automatic set_random();
    for (int i = 0; i < 8; i++) begin
      in_k[i]  = longint'($urandom_range(4095, 0)) - 2048;
      in_a2[i] = longint'($urandom_range(1024, 0));
      in_a3[i] = longint'($urandom_range(1024, 0));
      in_t[i]  = longint'($urandom_range(1024, 0));
    end
    for (int m = 0; m < 16; m++) in_w3[m] = longint'($urandom_range(8191, 0)) - 4096;
  endtask

  // One accepted sample; the model sees it and closes the batch when the DUT should.
  task automatic send(input int inst, input bit with_flush);
    drive_data(inst);
    check("in_ready_accum", longint'(ir[inst]), 1);
    iv[inst] = 1'b1;
    fl[inst] = with_flush;
    @(negedge clk);
    iv[inst] = 1'b0;
    fl[inst] = 1'b0;
    model_add(inst);
    if (m_cnt[inst] == C_BATCH[inst] || with_flush) model_close(inst);
  endtask

  task automatic flush_only(input int inst);
    fl[inst] = 1'b1;
    @(negedge clk);
    fl[inst] = 1'b0;
    if (m_cnt[inst] > 0) model_close(inst);
  endtask

  task automatic wait_out(input int inst, output int lat);
    lat = 0;
    while (!ov[inst] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", longint'(ov[inst]), 1);
  endtask

  task automatic check_out(input int inst);
    exp_t e;
    int w, nw3, nw2;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    w = C_W[inst];
    nw3 = C_NHID[inst] * C_NOUT[inst];
    nw2 = C_NIN[inst] * C_NHID[inst];
    check("sb_inst", inst, e.inst);
    check("out_count", longint'(oc_v[inst]), e.cnt);
    for (int m = 0; m < nw3; m++) check($sformatf("grad_w3[%0d]", m), elem(gw3_v[inst], m, w), e.w3[m]);
    for (int m = 0; m < nw2; m++) check($sformatf("grad_w2[%0d]", m), elem(gw2_v[inst], m, w), e.w2[m]);
    for (int m = 0; m < C_NOUT[inst]; m++) check($sformatf("grad_b3[%0d]", m), elem(gb3_v[inst], m, w), e.b3[m]);
    for (int m = 0; m < C_NHID[inst]; m++) check($sformatf("grad_b2[%0d]", m), elem(gb2_v[inst], m, w), e.b2[m]);
  endtask

  task automatic release_out(input int inst);
    ordy[inst] = 1'b1;
    @(negedge clk);
    ordy[inst] = 1'b0;
    check("out_valid_cleared", longint'(ov[inst]), 0);
    check("in_ready_back", longint'(ir[inst]), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      rs[i] = 1'b0; iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b0; m_cnt[i] = 0;
      for (int m = 0; m < 16; m++) begin m_w3[i][m] = 0; m_w2[i][m] = 0; end
      for (int m = 0; m < 8; m++) begin m_b3[i][m] = 0; m_b2[i][m] = 0; end
    end
    k_d = '0; a2_d = '0; a3_d = '0; t_d = '0; w3_d = '0;
    k_s = '0; a2_s = '0; a3_s = '0; t_s = '0; w3_s = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rs[i] = 1'b1;

    // Reset state
    for (int i = 0; i < 4; i++) begin
      check("rst_in_ready", longint'(ir[i]), 1);
      check("rst_out_valid", longint'(ov[i]), 0);
      check("rst_grad_b3", elem(gb3_v[i], 0, C_W[i]), 0);
      check("rst_grad_w2", elem(gw2_v[i], 0, C_W[i]), 0);
      check("rst_out_count", longint'(oc_v[i]), 0);
    end

    // Base sample, BATCH=1
    set_base(0, 512);
    send(0, 1'b0);
    wait_out(0, lat);
    check("base_latency", lat, 4);
    check("base_b3", elem(gb3_v[0], 0, 16), -128);
    check("base_w3", elem(gw3_v[0], 5, 16), -64);
    check("base_b2", elem(gb2_v[0], 2, 16), -64);
    check("base_w2", elem(gw2_v[0], 3, 16), -64);
    check_out(0);
    release_out(0);

    // Full batch of 4, then a few cycles of backpressure
    set_base(1, 512);
    for (int s = 0; s < 4; s++) send(1, 1'b0);
    check("b4_in_ready_low", longint'(ir[1]), 0);
    wait_out(1, lat);
    check("b4_latency", lat, 4);
    check("b4_b3", elem(gb3_v[1], 1, 16), -512);
    check("b4_w2", elem(gw2_v[1], 0, 16), -256);
    check_out(1);
    repeat (3) begin
      @(negedge clk);
      check("b4_hold_in_ready", longint'(ir[1]), 0);
      check("b4_hold_valid", longint'(ov[1]), 1);
    end
    release_out(1);

    // Flush with an empty batch does nothing
    flush_only(1);
    repeat (6) @(negedge clk);
    check("empty_flush_valid", longint'(ov[1]), 0);
    check("empty_flush_ready", longint'(ir[1]), 1);

    // Two samples, flush, then 10 cycles of backpressure
    send(1, 1'b0);
    send(1, 1'b0);
    flush_only(1);
    wait_out(1, lat);
    check("flush_count", longint'(oc_v[1]), 2);
    check("flush_b3", elem(gb3_v[1], 0, 16), -256);
    check_out(1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid", longint'(ov[1]), 1);
      check("bp_in_ready", longint'(ir[1]), 0);
      check("bp_b3_stable", elem(gb3_v[1], 0, 16), -256);
      check("bp_w2_stable", elem(gw2_v[1], 5, 16), -128);
    end
    release_out(1);

    // Saturation, BATCH=16
    set_base(2, 32767);
    for (int s = 0; s < 16; s++) send(2, 1'b0);
    wait_out(2, lat);
    check("sat_latency", lat, 4);
    check("sat_w3", elem(gw3_v[2], 0, 16), -32768);
    check("sat_b3", elem(gb3_v[2], 1, 16), -2048);
    check_out(2);
    release_out(2);

    // Reset during DRAIN discards the batch
    set_base(0, 512);
    drive_data(0);
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    rs[0] = 1'b0;
    @(negedge clk);
    rs[0] = 1'b1;
    check("mid_rst_in_ready", longint'(ir[0]), 1);
    check("mid_rst_valid", longint'(ov[0]), 0);
    check("mid_rst_b3", elem(gb3_v[0], 0, 16), 0);
    check("mid_rst_w3", elem(gw3_v[0], 0, 16), 0);
    check("mid_rst_count", longint'(oc_v[0]), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    check("mid_rst_no_valid", longint'(seen), 0);
    send(0, 1'b0);
    wait_out(0, lat);
    check("post_rst_b3", elem(gb3_v[0], 0, 16), -128);
    check_out(0);
    release_out(0);

    // Non-default shape 3-4-1, W=18, FRAC=12
    set_base(3, 2048);
    send(3, 1'b0);
    wait_out(3, lat);
    check("shape_latency", lat, 4);
    check("shape_b3", elem(gb3_v[3], 0, 18), -512);
    check("shape_w3", elem(gw3_v[3], 3, 18), -256);
    check("shape_b2", elem(gb2_v[3], 3, 18), -128);
    check("shape_w2", elem(gw2_v[3], 11, 18), -128);
    check_out(3);
    release_out(3);

    // Random samples: full batch, flush on the completing sample, flush on the 3rd
    for (int b = 0; b < 3; b++) begin
      int n;
      n = (b == 2) ? 3 : 4;
      for (int s = 0; s < n; s++) begin
        set_random();
        send(1, (b > 0) && (s == n - 1));
      end
      wait_out(1, lat);
      check("rand_latency", lat, 4);
      check_out(1);
      release_out(1);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
